// File: rtl/ring_osc_meas_ctrl.sv
// Ring-oscillator measurement sequencer: settles the ring, then runs 1..16
// clear/gate/hold/capture passes on the osc counter and reports sum, last, min and max.
module ring_osc_meas_ctrl #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned GATE_W        = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned ACC_W         = CNT_W + 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [3:0]        num_runs,
    input  logic [CNT_W-1:0]  cnt_in,
    output logic              ring_en,
    output logic              cnt_clr,
    output logic              cnt_gate,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ACC_W-1:0]  result,
    output logic [CNT_W-1:0]  last_cnt,
    output logic [CNT_W-1:0]  min_cnt,
    output logic [CNT_W-1:0]  max_cnt,
    output logic              sat
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CLEAR, S_GATE, S_HOLD, S_CAPTURE, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [GATE_W-1:0]  cyc_q, cyc_d;
    logic [GATE_W-1:0]  glen_q, glen_d;
    logic [3:0]         nruns_q, nruns_d;
    logic [3:0]         run_q, run_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   hi_q, hi_d;
    logic               ring_en_q, ring_en_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic               cnt_gate_q, cnt_gate_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   last_cnt_q, last_cnt_d;
    logic [CNT_W-1:0]   min_cnt_q, min_cnt_d;
    logic [CNT_W-1:0]   max_cnt_q, max_cnt_d;
    logic               sat_q, sat_d;

    // Next state and datapath; outputs are decoded from the next state so they align with it.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        glen_d     = glen_q;
        nruns_d    = nruns_q;
        run_d      = run_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        result_d   = result_q;
        last_cnt_d = last_cnt_q;
        min_cnt_d  = min_cnt_q;
        max_cnt_d  = max_cnt_q;
        sat_d      = sat_q;
        aborted_d  = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        glen_d  = (gate_len == '0) ? GATE_W'(1) : gate_len;
                        nruns_d = num_runs;
                        run_d   = 4'd0;
                        cyc_d   = '0;
                        acc_d   = '0;
                        lo_d    = CNT_ONES;
                        hi_d    = '0;
                        sat_d   = 1'b0;
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cyc_q == GATE_W'(SETTLE_CYCLES - 1)) begin
                        cyc_d   = '0;
                        state_d = S_CLEAR;
                    end else begin
                        cyc_d = cyc_q + GATE_W'(1);
                    end
                end
                S_CLEAR: begin
                    cyc_d   = '0;
                    state_d = S_GATE;
                end
                S_GATE: begin
                    if (cyc_q == glen_q - GATE_W'(1)) begin
                        cyc_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        cyc_d = cyc_q + GATE_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cyc_q == GATE_W'(HOLD_CYCLES - 1)) begin
                        cyc_d   = '0;
                        state_d = S_CAPTURE;
                    end else begin
                        cyc_d = cyc_q + GATE_W'(1);
                    end
                end
                S_CAPTURE: begin
                    last_cnt_d = cnt_in;
                    acc_d      = acc_q + ACC_W'(cnt_in);
                    if (cnt_in < lo_q) lo_d = cnt_in;
                    if (cnt_in > hi_q) hi_d = cnt_in;
                    if (cnt_in == CNT_ONES) sat_d = 1'b1;
                    if (run_q == nruns_q) begin
                        // Publish with the done pulse so results are valid when it is seen.
                        result_d  = acc_d;
                        min_cnt_d = lo_d;
                        max_cnt_d = hi_d;
                        state_d   = S_DONE;
                    end else begin
                        run_d   = run_q + 4'd1;
                        state_d = S_CLEAR;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d     = (state_d != S_IDLE);
        ring_en_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        cnt_clr_d  = (state_d == S_CLEAR);
        cnt_gate_d = (state_d == S_GATE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            glen_q     <= '0;
            nruns_q    <= '0;
            run_q      <= '0;
            acc_q      <= '0;
            lo_q       <= CNT_ONES;
            hi_q       <= '0;
            ring_en_q  <= 1'b0;
            cnt_clr_q  <= 1'b0;
            cnt_gate_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            result_q   <= '0;
            last_cnt_q <= '0;
            min_cnt_q  <= CNT_ONES;
            max_cnt_q  <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            glen_q     <= glen_d;
            nruns_q    <= nruns_d;
            run_q      <= run_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            ring_en_q  <= ring_en_d;
            cnt_clr_q  <= cnt_clr_d;
            cnt_gate_q <= cnt_gate_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            result_q   <= result_d;
            last_cnt_q <= last_cnt_d;
            min_cnt_q  <= min_cnt_d;
            max_cnt_q  <= max_cnt_d;
            sat_q      <= sat_d;
        end
    end

    assign ring_en  = ring_en_q;
    assign cnt_clr  = cnt_clr_q;
    assign cnt_gate = cnt_gate_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign result   = result_q;
    assign last_cnt = last_cnt_q;
    assign min_cnt  = min_cnt_q;
    assign max_cnt  = max_cnt_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Directed bench for ring_osc_meas_ctrl: expected sequence results are queued at
// start and compared when done pulses; per-cycle invariants are checked on every tick.
module tb_ring_osc_meas_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [15:0] gate_len;
    logic [3:0]  num_runs;
    logic [15:0] cnt_in;
    logic        ring_en, cnt_clr, cnt_gate, busy, done, aborted, sat;
    logic [19:0] result;
    logic [15:0] last_cnt, min_cnt, max_cnt;

    ring_osc_meas_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .gate_len(gate_len), .num_runs(num_runs), .cnt_in(cnt_in),
        .ring_en(ring_en), .cnt_clr(cnt_clr), .cnt_gate(cnt_gate),
        .busy(busy), .done(done), .aborted(aborted), .result(result),
        .last_cnt(last_cnt), .min_cnt(min_cnt), .max_cnt(max_cnt), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] res;
        logic [15:0] mn;
        logic [15:0] mx;
        logic [15:0] last;
        logic        sat;
        int unsigned cyc;
        int unsigned nclr;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] cap_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned gcur = 0;
    int unsigned exp_g = 1;
    int unsigned nclr = 0;
    logic        gate_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge, feed the next capture value on each clear.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cnt_clr) begin
            nclr++;
            if (cap_q.size() > 0) cnt_in = cap_q.pop_front();
        end
        if (cnt_gate) begin
            gcur++;
        end else begin
            if (gate_prev && !aborted) chk("gate_cycles", gcur, exp_g);
            gcur = 0;
        end
        gate_prev = cnt_gate;
        chk("clr_gate_exclusive", {31'd0, cnt_clr & cnt_gate}, 32'd0);
        chk("ring_en_vs_busy", {31'd0, ring_en}, {31'd0, busy & ~done});
    endtask

    task automatic run_seq(input int unsigned g, input int unsigned r,
                           input logic poke, input logic with_abort);
        exp_t        e;
        int unsigned s0;
        int unsigned gg;
        int unsigned budget;
        gg     = (g == 0) ? 1 : g;
        exp_g  = gg;
        e.res  = '0;
        e.mn   = 16'hFFFF;
        e.mx   = 16'h0000;
        e.last = 16'h0000;
        e.sat  = 1'b0;
        for (int i = 0; i <= int'(r); i++) begin
            e.res = e.res + 20'(cap_q[i]);
            if (cap_q[i] < e.mn) e.mn = cap_q[i];
            if (cap_q[i] > e.mx) e.mx = cap_q[i];
            e.last = cap_q[i];
            if (cap_q[i] == 16'hFFFF) e.sat = 1'b1;
        end
        e.cyc  = 1 + 8 + (r + 1) * (gg + 6);
        e.nclr = r + 1;
        sb.push_back(e);

        gate_len = 16'(g);
        num_runs = 4'(r);
        start    = 1'b1;
        abort    = with_abort;
        s0       = cyc;
        nclr     = 0;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ring_en_after_start", {31'd0, ring_en}, 32'd1);

        budget = 0;
        while (!done && budget < 2000) begin
            if (poke && (cyc - s0 == 12)) begin
                start    = 1'b1;
                gate_len = 16'd3;
                num_runs = 4'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            budget++;
        end
        start = 1'b0;

        if (!done) begin
            chk("done_timeout", {31'd0, done}, 32'd1);
            sb.delete();
        end else begin
            e = sb.pop_front();
            chk("done_cycle", cyc - s0, e.cyc);
            chk("result", 32'(result), 32'(e.res));
            chk("min_cnt", 32'(min_cnt), 32'(e.mn));
            chk("max_cnt", 32'(max_cnt), 32'(e.mx));
            chk("last_cnt", 32'(last_cnt), 32'(e.last));
            chk("sat", {31'd0, sat}, {31'd0, e.sat});
            chk("clr_pulses", nclr, e.nclr);
        end
        tick();
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int unsigned budget;
        logic        seen_done;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        gate_len = '0; num_runs = '0; cnt_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ring_en", {31'd0, ring_en}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_min", 32'(min_cnt), 32'h0000FFFF);
        chk("rst_max", 32'(max_cnt), 32'd0);
        chk("rst_last", 32'(last_cnt), 32'd0);
        chk("rst_sat", {31'd0, sat}, 32'd0);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_no_pulse", {31'd0, aborted}, 32'd0);
        chk("abort_idle_not_busy", {31'd0, busy}, 32'd0);

        // Single run, gate 10.
        cap_q = '{16'd1234};
        run_seq(10, 0, 1'b0, 1'b0);

        // Four runs with a start poke while busy that must be ignored.
        cap_q = '{16'd100, 16'd105, 16'd98, 16'd101};
        run_seq(5, 3, 1'b1, 1'b0);

        // gate_len 0 behaves as 1.
        cap_q = '{16'd7, 16'd3};
        run_seq(0, 1, 1'b0, 1'b0);

        // Abort in the 3rd GATE cycle of run 2.
        cap_q    = '{16'd11, 16'd22, 16'd33};
        exp_g    = 6;
        gate_len = 16'd6;
        num_runs = 4'd2;
        nclr     = 0;
        start    = 1'b1;
        tick();
        start  = 1'b0;
        budget = 0;
        while (!(nclr == 2 && gcur == 3) && budget < 200) begin
            tick();
            budget++;
        end
        chk("abort_point_reached", {31'd0, cnt_gate}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", {31'd0, aborted}, 32'd1);
        chk("abort_ring_en", {31'd0, ring_en}, 32'd0);
        chk("abort_cnt_gate", {31'd0, cnt_gate}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result_kept", 32'(result), 32'd10);
        seen_done = 1'b0;
        tick();
        chk("abort_pulse_one_cycle", {31'd0, aborted}, 32'd0);
        repeat (40) begin
            seen_done = seen_done | done;
            tick();
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        chk("abort_result_still_kept", 32'(result), 32'd10);
        cap_q.delete();

        // Sixteen full-scale runs.
        for (int i = 0; i < 16; i++) cap_q.push_back(16'hFFFF);
        run_seq(1, 15, 1'b0, 1'b0);

        // Reset during HOLD (cycle 15 of a gate-4 run).
        cap_q    = '{16'd500};
        exp_g    = 4;
        gate_len = 16'd4;
        num_runs = 4'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        chk("hold_reached_busy", {31'd0, busy & ~cnt_gate & ~cnt_clr}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ring_en", {31'd0, ring_en}, 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_min", 32'(min_cnt), 32'h0000FFFF);
        chk("mid_rst_max", 32'(max_cnt), 32'd0);
        chk("mid_rst_last", 32'(last_cnt), 32'd0);
        chk("mid_rst_sat", {31'd0, sat}, 32'd0);
        cap_q.delete();
        tick();

        // Subsequent start, issued together with abort in IDLE (start wins).
        cap_q = '{16'd50, 16'd60};
        run_seq(2, 1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
